// File: rtl/ld_cell_sched_if.sv
//------------------------------------------------------------------------------
// Module      : ld_cell_sched_if
// Description : SPI master handshake between the cell scheduler and the SPI
//               master. The scheduler launches a transaction with a one-cycle
//               wrt strobe and a command word; the SPI master answers with a
//               one-cycle done pulse and the word it read back.
//   wrt     : start strobe to the SPI master (scheduler -> SPI)
//   cmd     : 16-bit command word           (scheduler -> SPI)
//   done    : transaction complete pulse    (SPI -> scheduler)
//   rd_data : 16-bit read word              (SPI -> scheduler)
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface ld_cell_sched_if;
  logic        wrt;
  logic [15:0] cmd;
  logic        done;
  logic [15:0] rd_data;

  modport master (output wrt, output cmd, input done, input rd_data);
  modport slave  (input wrt, input cmd, output done, output rd_data);
endinterface

`default_nettype wire

// File: rtl/ld_cell_sched.sv
//------------------------------------------------------------------------------
// Module      : ld_cell_sched
// Description : Shares one SPI A2D between four channels in fixed round-robin
//               order (lft=chnl 0, rght=chnl 4, steer_pot=chnl 5, batt=chnl 6).
//               Each conversion issues the channel command twice (convert,
//               then read back) with a one-cycle gap, and stores the 12-bit
//               result. A wait counter aborts a stalled transaction.
// Ports       :
//   clk        : system clock
//   rst_n      : asynchronous active-low reset
//   nxt        : request one conversion on the current channel
//   spi        : SPI master handshake (wrt/cmd out, done/rd_data in)
//   lft_ld, rght_ld, steer_pot, batt : latest 12-bit result per channel
//   upd        : one-cycle pulse when a channel register is written
//   tmo        : one-cycle pulse when a transaction is aborted
//   busy       : high whenever the scheduler is not idle
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module ld_cell_sched #(
  parameter int TMO_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   nxt,
  ld_cell_sched_if.master        spi,
  output logic [11:0]            lft_ld,
  output logic [11:0]            rght_ld,
  output logic [11:0]            steer_pot,
  output logic [11:0]            batt,
  output logic                   upd,
  output logic                   tmo,
  output logic                   busy
);

  localparam int               CNT_W    = (TMO_CYCLES > 1) ? $clog2(TMO_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TMO_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CNV  = 2'd1,
    GAP  = 2'd2,
    RD   = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       ptr;
  logic [CNT_W-1:0] cnt;
  logic             armed;
  logic             wrt_c;
  logic             wr_en;
  logic             tmo_c;
  logic             cnt_run;
  logic             cnt_done;
  logic [2:0]       chnl;
  logic             unused_rd_hi;

  // Only the low 12 bits of the read word carry the conversion result.
  assign unused_rd_hi = ^spi.rd_data[15:12];

  // Channel number for the round-robin slot.
  always_comb begin
    chnl = 3'd0;
    case (ptr)
      2'd0:    chnl = 3'd0;
      2'd1:    chnl = 3'd4;
      2'd2:    chnl = 3'd5;
      default: chnl = 3'd6;
    endcase
  end

  // The pointer only moves when a read completes, so the command is stable
  // across both strobes of a transaction and reads 16'h0000 out of reset.
  assign spi.cmd  = {2'b00, chnl, 11'h000};
  assign spi.wrt  = wrt_c;
  assign busy     = (state != IDLE);
  assign cnt_done = (cnt == CNT_LAST);

  always_comb begin
    state_nxt = state;
    wrt_c     = 1'b0;
    wr_en     = 1'b0;
    tmo_c     = 1'b0;
    case (state)
      IDLE: begin
        // armed is low while reset is asserted, which keeps the combinational
        // start strobe quiet during reset regardless of nxt.
        if (nxt && armed) begin
          wrt_c     = 1'b1;
          state_nxt = CNV;
        end
      end
      CNV: begin
        // done is tested first so it wins over a coincident terminal count.
        if (spi.done) begin
          state_nxt = GAP;
        end else if (cnt_done) begin
          tmo_c     = 1'b1;
          state_nxt = IDLE;
        end
      end
      GAP: begin
        wrt_c     = 1'b1;
        state_nxt = RD;
      end
      RD: begin
        if (spi.done) begin
          wr_en     = 1'b1;
          state_nxt = IDLE;
        end else if (cnt_done) begin
          tmo_c     = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Counter runs only while staying in a waiting state; any state change
    // (including entry into CNV/RD) clears it.
    cnt_run = ((state == CNV) || (state == RD)) && (state_nxt == state);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= 2'd0;
      cnt       <= '0;
      armed     <= 1'b0;
      upd       <= 1'b0;
      tmo       <= 1'b0;
      lft_ld    <= 12'h000;
      rght_ld   <= 12'h000;
      steer_pot <= 12'h000;
      batt      <= 12'h000;
    end else begin
      state <= state_nxt;
      armed <= 1'b1;
      upd   <= wr_en;
      tmo   <= tmo_c;
      if (cnt_run) begin
        cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
      end
      if (wr_en) begin
        ptr <= ptr + 2'd1;
        case (ptr)
          2'd0:    lft_ld    <= spi.rd_data[11:0];
          2'd1:    rght_ld   <= spi.rd_data[11:0];
          2'd2:    steer_pot <= spi.rd_data[11:0];
          default: batt      <= spi.rd_data[11:0];
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ld_cell_sched.sv
//------------------------------------------------------------------------------
// Module      : tb_ld_cell_sched
// Description : Self-checking bench for ld_cell_sched. A driver plays the SPI
//               slave cycle by cycle and, from a channel/pointer model, queues
//               the expected strobes (cycle + cmd) and the expected upd/tmo
//               events (cycle + register snapshot). A monitor on the falling
//               edge pops and compares whatever the DUT presents.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_ld_cell_sched;

  localparam int TMO = 16;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        nxt   = 1'b0;
  logic [11:0] lft_ld, rght_ld, steer_pot, batt;
  logic        upd, tmo, busy;
  int          cyc   = 0;

  ld_cell_sched_if spi ();

  ld_cell_sched #(.TMO_CYCLES(TMO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .nxt       (nxt),
    .spi       (spi),
    .lft_ld    (lft_ld),
    .rght_ld   (rght_ld),
    .steer_pot (steer_pot),
    .batt      (batt),
    .upd       (upd),
    .tmo       (tmo),
    .busy      (busy)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [15:0] cmd;
  } wrt_t;

  typedef struct {
    int                cyc;
    bit                is_tmo;
    logic [3:0][11:0]  r;
  } evt_t;

  wrt_t exp_wrt[$];
  evt_t exp_evt[$];

  // Reference model: channel registers and round-robin slot.
  logic [11:0] m_reg [4];
  int          m_ptr;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] cmd_of(input int p);
    int chn [4] = '{0, 4, 5, 6};
    logic [2:0] c;
    c = 3'(chn[p]);
    return {2'b00, c, 11'h000};
  endfunction

  function automatic bit noise();
    return ($urandom_range(0, 3) == 0);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_reg[i] = 12'h000;
    m_ptr = 0;
  endtask

  task automatic push_wrt(input int c);
    wrt_t w;
    w.cyc = c;
    w.cmd = cmd_of(m_ptr);
    exp_wrt.push_back(w);
  endtask

  task automatic push_evt(input int c, input bit t);
    evt_t e;
    e.cyc    = c;
    e.is_tmo = t;
    for (int i = 0; i < 4; i++) e.r[i] = m_reg[i];
    exp_evt.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every strobe / event the DUT presents.
  always @(negedge clk) begin
    if (rst_n) begin
      if (spi.wrt) begin
        if (exp_wrt.size() == 0) begin
          chk("wrt_unexpected", 32'(spi.wrt), 32'd0);
        end else begin
          wrt_t w;
          w = exp_wrt.pop_front();
          chk("wrt_cycle", 32'(cyc), 32'(w.cyc));
          chk("cmd", 32'(spi.cmd), 32'(w.cmd));
        end
      end
      if (upd || tmo) begin
        if (exp_evt.size() == 0) begin
          chk("evt_unexpected", {30'd0, upd, tmo}, 32'd0);
        end else begin
          evt_t e;
          e = exp_evt.pop_front();
          chk("evt_kind", {30'd0, upd, tmo}, e.is_tmo ? 32'd1 : 32'd2);
          chk("evt_cycle", 32'(cyc), 32'(e.cyc));
          chk("lft_ld", 32'(lft_ld), 32'(e.r[0]));
          chk("rght_ld", 32'(rght_ld), 32'(e.r[1]));
          chk("steer_pot", 32'(steer_pot), 32'(e.r[2]));
          chk("batt", 32'(batt), 32'(e.r[3]));
          chk("busy_after_evt", 32'(busy), 32'd0);
        end
      end
    end
  end

  // One transaction starting in the current (idle) cycle. d1/d2 are the wait
  // cycles before done in the convert and read phases; >= TMO means never.
  task automatic run_txn(input int d1, input int d2, input bit hold, input logic [15:0] dat);
    int n0;
    int g;
    n0 = cyc;
    nxt = 1'b1;
    spi.done = 1'b0;
    push_wrt(n0);
    for (int k = 0; k < TMO; k++) begin
      tick();
      nxt = hold | noise();
      spi.done = (k == d1);
      spi.rd_data = (k == d1) ? dat : 16'($urandom);
      if (k == d1) break;
    end
    if (d1 >= TMO) begin
      push_evt(n0 + 1 + TMO, 1'b1);
    end else begin
      tick();
      g = cyc;
      nxt = hold | noise();
      spi.done = noise();
      spi.rd_data = 16'($urandom);
      push_wrt(g);
      for (int k = 0; k < TMO; k++) begin
        tick();
        nxt = hold | noise();
        spi.done = (k == d2);
        spi.rd_data = (k == d2) ? dat : 16'($urandom);
        if (k == d2) break;
      end
      if (d2 >= TMO) begin
        push_evt(g + 1 + TMO, 1'b1);
      end else begin
        m_reg[m_ptr] = dat[11:0];
        m_ptr = (m_ptr + 1) % 4;
        push_evt(g + 2 + d2, 1'b0);
      end
    end
    tick();
    nxt = 1'b0;
    spi.done = noise();
    spi.rd_data = 16'($urandom);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      nxt = 1'b0;
      spi.done = noise();
      spi.rd_data = 16'($urandom);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_wrt"}, 32'(spi.wrt), 32'd0);
    chk({tag, "_upd"}, 32'(upd), 32'd0);
    chk({tag, "_tmo"}, 32'(tmo), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_cmd"}, 32'(spi.cmd), 32'd0);
    chk({tag, "_regs"}, 32'({lft_ld, rght_ld}) | 32'({steer_pot, batt}), 32'd0);
  endtask

  task automatic release_reset();
    tick();
    nxt = 1'b0;
    spi.done = 1'b0;
    rst_n = 1'b1;
    idle_cycles(2);
  endtask

  function automatic int pick_d();
    int r;
    r = $urandom_range(0, 9);
    if (r == 7) return TMO - 1;
    if (r == 8) return TMO;
    return $urandom_range(0, 3);
  endfunction

  initial begin
    model_reset();
    spi.done = 1'b0;
    spi.rd_data = 16'h0000;
    nxt = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    nxt = 1'b0;
    release_reset();

    // Basic conversion on lft with a minimum-latency SPI slave.
    run_txn(0, 0, 1'b0, 16'hF123);
    idle_cycles(2);
    chk("lft_after_first", 32'(lft_ld), 32'h123);

    // Reset, then one full round through all four channels and back to lft.
    rst_n = 1'b0;
    #2;
    model_reset();
    release_reset();
    run_txn(0, 0, 1'b0, 16'h0111);
    run_txn(0, 0, 1'b0, 16'h0222);
    run_txn(1, 2, 1'b0, 16'h0333);
    run_txn(0, 0, 1'b0, 16'h0444);
    run_txn(0, 0, 1'b0, 16'h0555);
    idle_cycles(2);

    // nxt held high across back-to-back transactions.
    for (int i = 0; i < 4; i++) run_txn($urandom_range(0, 2), $urandom_range(0, 2), 1'b1, 16'($urandom));
    idle_cycles(2);

    // Timeout in the convert phase, then retry on the same channel.
    run_txn(TMO, 0, 1'b0, 16'h0ABC);
    run_txn(0, 0, 1'b0, 16'h0ABC);
    // Timeout in the read phase.
    run_txn(0, TMO, 1'b0, 16'h0DEF);
    // done coincident with the terminal count in each waiting state.
    run_txn(0, TMO - 1, 1'b0, 16'h0777);
    run_txn(TMO - 1, 0, 1'b0, 16'h0888);
    idle_cycles(2);

    // Reset asserted in the read phase with done pending.
    begin
      int g;
      push_wrt(cyc);
      nxt = 1'b1;
      spi.done = 1'b0;
      tick();
      nxt = 1'b0;
      spi.done = 1'b1;
      spi.rd_data = 16'h0ABD;
      tick();
      g = cyc;
      spi.done = 1'b0;
      push_wrt(g);
      tick();
      spi.done = 1'b1;
      spi.rd_data = 16'h0FFF;
      #2;
      rst_n = 1'b0;
      #2;
      model_reset();
      check_reset_outputs("midrd_reset");
    end
    release_reset();
    run_txn(0, 0, 1'b0, 16'h0246);
    idle_cycles(1);

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      run_txn(pick_d(), pick_d(), 1'($urandom_range(0, 1)), 16'($urandom));
      if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 3));
    end
    idle_cycles(4);

    chk("wrt_queue_drained", 32'(exp_wrt.size()), 32'd0);
    chk("evt_queue_drained", 32'(exp_evt.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/ld_cell_sched.md
LD_CELL_SCHED -- requirements
Module: ld_cell_sched

Interface
REQ-001 SHALL have parameter TMO_CYCLES, default 1024, meaning cycles to wait for SPI done before a transaction is aborted.
REQ-002 SHALL have port clk, input, 1 bit: the single system clock, 50 MHz.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port nxt, input, 1 bit: request to start one conversion on the current channel.
REQ-005 SHALL have port wrt, output, 1 bit: one-cycle start strobe to the SPI master.
REQ-006 SHALL have port cmd, output, 16 bits: SPI command word.
REQ-007 SHALL have port done, input, 1 bit: SPI transaction complete, one-cycle pulse.
REQ-008 SHALL have port rd_data, input, 16 bits: SPI read word.
REQ-009 SHALL have ports lft_ld, rght_ld, steer_pot, batt, outputs, 12 bits each: latest conversion per channel.
REQ-010 SHALL have port upd, output, 1 bit: one-cycle pulse when any channel register is written.
REQ-011 SHALL have port tmo, output, 1 bit: one-cycle pulse when a transaction is aborted.
REQ-012 SHALL have port busy, output, 1 bit: high whenever the FSM is outside IDLE.

Function
REQ-013 SHALL share one A2D between four channels in fixed round-robin order: lft (chnl 0), rght (chnl 4), steer_pot (chnl 5), batt (chnl 6).
REQ-014 SHALL hold a 2-bit round-robin pointer (0..3) that advances only on a successful read, wrapping 3->0.
REQ-015 SHALL drive cmd = {2'b00, chnl[2:0], 11'h000} for the channel selected by the pointer, stable from wrt until the read completes.
REQ-016 SHALL implement FSM states IDLE, CNV, GAP, RD.
REQ-017 IDLE: on nxt=1, SHALL pulse wrt in the same cycle and go to CNV.
REQ-018 CNV: on done=1, SHALL go to GAP.
REQ-019 GAP: SHALL spend exactly one cycle, then pulse wrt (same cmd) and go to RD.
REQ-020 RD: on done=1, SHALL write rd_data[11:0] into the pointed channel register, pulse upd, advance the pointer and return to IDLE.
REQ-021 Register write and upd SHALL occur in the clock edge after done is sampled; the new value is visible one cycle after done.
REQ-022 SHALL ignore nxt outside IDLE; requests are not queued.
REQ-023 SHALL ignore done in IDLE and GAP.
REQ-024 SHALL run a wait counter in CNV and RD, cleared on every state entry.
REQ-025 If the counter reaches TMO_CYCLES-1 without done, SHALL pulse tmo, return to IDLE, and leave the pointer and all channel registers unchanged.
REQ-026 If done and the timeout terminal count occur in the same cycle, done SHALL win and tmo SHALL stay low.
REQ-027 wrt, upd and tmo SHALL never be high for more than one consecutive cycle.
REQ-028 Minimum conversion latency from nxt to upd SHALL be 4 cycles when done returns one cycle after each wrt.

Reset
REQ-029 On rst_n=0, SHALL asynchronously enter IDLE, with pointer=0, wait counter=0, and all channel registers=12'h000.
REQ-030 On reset, outputs wrt, upd, tmo and busy SHALL be 0, and cmd SHALL be 16'h0000.
REQ-031 Reset asserted mid-transaction SHALL abort without writing any channel register; the first nxt after release SHALL target lft (chnl 0).

Verification
REQ-032 Reset then nxt, done/rd_data=16'hF123 twice -> cmd=16'h0000, lft_ld=12'h123, upd one pulse, pointer->rght.
REQ-033 Four consecutive conversions returning 12'h111/222/333/444 -> cmd 0000/2000/2800/3000; lft=111, rght=222, steer=333, batt=444; fifth conversion targets lft again.
REQ-034 nxt held high continuously -> exactly one wrt per transaction, and the next conversion starts only after return to IDLE.
REQ-035 No done after first wrt -> tmo pulses TMO_CYCLES cycles after CNV entry, busy drops, pointer and registers unchanged; the retry targets the same channel.
REQ-036 done coincident with the timeout terminal count in RD -> register written, upd=1, tmo=0.
REQ-037 rst_n pulsed low while in RD with done pending -> all outputs 0, no register write, and the next conversion uses cmd=16'h0000.
